// File: rtl/fir_sequencer.sv
// Moore controller sequencing the shared FIR register file, ALU and multiplier.
// Outputs are registered, decoded from the next state and counters.
module fir_sequencer #(
    parameter int NUM_TAPS = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       dr,
    input  logic       lc,
    input  logic       overflow,
    output logic [2:0] op,
    output logic [3:0] src1,
    output logic [3:0] src2,
    output logic [3:0] dest,
    output logic       cnt_up,
    output logic       modwait,
    output logic       err
);

    localparam logic [2:0] N3   = 3'(NUM_TAPS);
    localparam logic [3:0] N4   = 4'(NUM_TAPS);
    localparam logic [3:0] TMP  = 4'(2 * NUM_TAPS + 1);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_COPY  = 3'b001;
    localparam logic [2:0] OP_LOAD1 = 3'b010;
    localparam logic [2:0] OP_LOAD2 = 3'b011;
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_SUB   = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;

    typedef enum logic [2:0] {
        IDLE, COEFF, SHIFT, STORE, ZERO, MUL, ACC, ERR
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] k_q, k_d;
    logic [2:0] cidx_q, cidx_d;

    logic [2:0] op_q, op_d;
    logic [3:0] src1_q, src1_d;
    logic [3:0] src2_q, src2_d;
    logic [3:0] dest_q, dest_d;
    logic       cnt_up_q, cnt_up_d;
    logic       modwait_q, modwait_d;
    logic       err_q, err_d;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cidx_d  = cidx_q;
        unique case (state_q)
            IDLE, ERR: begin
                if (lc) begin
                    state_d = COEFF;
                end else if (dr) begin
                    state_d = SHIFT;
                    k_d     = 3'd1;
                end
            end
            COEFF: begin
                state_d = IDLE;
                cidx_d  = (cidx_q == N3 - 3'd1) ? 3'd0 : cidx_q + 3'd1;
            end
            SHIFT: begin
                if (k_q == N3 - 3'd1) state_d = STORE;
                else                  k_d     = k_q + 3'd1;
            end
            STORE: state_d = dr ? ZERO : ERR;
            ZERO: begin
                state_d = MUL;
                k_d     = 3'd1;
            end
            MUL: state_d = ACC;
            ACC: begin
                if (overflow) begin
                    state_d = ERR;
                end else if (k_q == N3) begin
                    state_d = IDLE;
                end else begin
                    state_d = MUL;
                    k_d     = k_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Decode the outputs of the state being entered so they are valid
    // for the whole cycle spent in it.
    always_comb begin
        op_d      = OP_NOP;
        src1_d    = 4'd0;
        src2_d    = 4'd0;
        dest_d    = 4'd0;
        cnt_up_d  = 1'b0;
        modwait_d = (state_d != IDLE) && (state_d != ERR);
        err_d     = (state_d == ERR);
        unique case (state_d)
            COEFF: begin
                op_d   = OP_LOAD2;
                dest_d = N4 + 4'd1 + {1'b0, cidx_d};
            end
            SHIFT: begin
                op_d   = OP_COPY;
                src1_d = {1'b0, k_d} + 4'd1;
                dest_d = {1'b0, k_d};
            end
            STORE: begin
                op_d     = OP_LOAD1;
                dest_d   = N4;
                cnt_up_d = 1'b1;
            end
            ZERO: op_d = OP_SUB;
            MUL: begin
                op_d   = OP_MUL;
                src1_d = {1'b0, k_d};
                src2_d = N4 + {1'b0, k_d};
                dest_d = TMP;
            end
            ACC: begin
                op_d   = OP_ADD;
                src2_d = TMP;
            end
            default: op_d = OP_NOP;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            k_q       <= 3'd0;
            cidx_q    <= 3'd0;
            op_q      <= OP_NOP;
            src1_q    <= 4'd0;
            src2_q    <= 4'd0;
            dest_q    <= 4'd0;
            cnt_up_q  <= 1'b0;
            modwait_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            cidx_q    <= cidx_d;
            op_q      <= op_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            dest_q    <= dest_d;
            cnt_up_q  <= cnt_up_d;
            modwait_q <= modwait_d;
            err_q     <= err_d;
        end
    end

    assign op      = op_q;
    assign src1    = src1_q;
    assign src2    = src2_q;
    assign dest    = dest_q;
    assign cnt_up  = cnt_up_q;
    assign modwait = modwait_q;
    assign err     = err_q;

endmodule

// File: tb/tb_fir_sequencer.sv
// Bench for fir_sequencer: expected per-cycle output traces are built from
// the sequencing rules and replayed against the DUT with matching inputs.
module tb_fir_sequencer;

    localparam int N = 4;

    logic       clk;
    logic       n_rst;
    logic       dr;
    logic       lc;
    logic       overflow;
    logic [2:0] op;
    logic [3:0] src1;
    logic [3:0] src2;
    logic [3:0] dest;
    logic       cnt_up;
    logic       modwait;
    logic       err;
    logic [17:0] obs;

    int n_assert = 0;
    int n_fail   = 0;

    fir_sequencer #(.NUM_TAPS(N)) dut (
        .clk(clk), .n_rst(n_rst), .dr(dr), .lc(lc), .overflow(overflow),
        .op(op), .src1(src1), .src2(src2), .dest(dest),
        .cnt_up(cnt_up), .modwait(modwait), .err(err)
    );

    assign obs = {op, src1, src2, dest, cnt_up, modwait, err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [17:0] exp_q[$];
    bit          dri_q[$];
    bit          lci_q[$];
    bit          ovi_q[$];
    string       nm_q[$];
    bit          in_err = 1'b0;
    int          cidx   = 0;

    function automatic logic [17:0] pk(int o, int s1, int s2, int d,
                                       bit cu, bit mw, bit er);
        return {3'(o), 4'(s1), 4'(s2), 4'(d), cu, mw, er};
    endfunction

    function automatic bit nz(bit en);
        return en ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    function automatic logic [17:0] rest_e();
        return in_err ? pk(0, 0, 0, 0, 0, 0, 1) : pk(0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic add(logic [17:0] e, bit d, bit l, bit o, string nm);
        exp_q.push_back(e);
        dri_q.push_back(d);
        lci_q.push_back(l);
        ovi_q.push_back(o);
        nm_q.push_back(nm);
    endtask

    task automatic rest(int n);
        for (int i = 0; i < n; i++)
            add(rest_e(), 0, 0, 0, in_err ? "err" : "idle");
    endtask

    task automatic coeff(bit noisy);
        add(rest_e(), 0, 1, 0, "rest_lc");
        in_err = 1'b0;
        add(pk(3, 0, 0, N + 1 + cidx, 0, 1, 0), nz(noisy), nz(noisy), 0, "coeff");
        cidx = (cidx + 1) % N;
    endtask

    // One accepted sample; ov_at selects the ACC step that overflows (0 = none).
    task automatic sample(int ov_at, bit drop, bit noisy);
        add(rest_e(), 1, 0, 0, "rest_dr");
        in_err = 1'b0;
        for (int k = 1; k < N; k++)
            add(pk(1, k + 1, 0, k, 0, 1, 0), 1, nz(noisy), 0, "shift");
        add(pk(2, 0, 0, N, 1, 1, 0), !drop, nz(noisy), 0, "store");
        if (drop) begin
            in_err = 1'b1;
            return;
        end
        add(pk(5, 0, 0, 0, 0, 1, 0), nz(noisy), nz(noisy), 0, "zero");
        for (int k = 1; k <= N; k++) begin
            add(pk(6, k, N + k, 2 * N + 1, 0, 1, 0), nz(noisy), nz(noisy), 0, "mul");
            add(pk(4, 0, 2 * N + 1, 0, 0, 1, 0), nz(noisy), nz(noisy), k == ov_at, "acc");
            if (k == ov_at) begin
                in_err = 1'b1;
                return;
            end
        end
    endtask

    task automatic play(output logic [17:0] got, output logic [17:0] want,
                        output string nm);
        @(negedge clk);
        got      = obs;
        want     = exp_q.pop_front();
        nm       = nm_q.pop_front();
        dr       = dri_q.pop_front();
        lc       = lci_q.pop_front();
        overflow = ovi_q.pop_front();
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        dr = 1'b0;
        lc = 1'b0;
        overflow = 1'b0;
        repeat (2) @(negedge clk);
        n_assert++;
        if (obs !== 18'd0) begin
            n_fail++;
            $display("FAIL reset: got %h want %h", obs, 18'd0);
        end
        n_rst = 1'b1;
    endtask

    task automatic test_coeff();
        logic [17:0] g, w;
        string nm;
        for (int i = 0; i < N + 1; i++) begin
            coeff(0);
            rest($urandom_range(0, 2));
        end
        rest(1);
        while (exp_q.size() > 0) begin
            play(g, w, nm);
            n_assert++;
            if (g !== w) begin
                n_fail++;
                $display("FAIL coeff/%s: got %h want %h", nm, g, w);
            end
        end
    endtask

    task automatic test_sample();
        logic [17:0] g, w;
        string nm;
        int mw_cnt = 0;
        int cu_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            sample(0, 0, 0);
            rest($urandom_range(1, 3));
        end
        while (exp_q.size() > 0) begin
            play(g, w, nm);
            mw_cnt += int'(g[1]);
            cu_cnt += int'(g[2]);
            n_assert++;
            if (g !== w) begin
                n_fail++;
                $display("FAIL sample/%s: got %h want %h", nm, g, w);
            end
        end
        n_assert++;
        if (mw_cnt != 3 * (3 * N + 1)) begin
            n_fail++;
            $display("FAIL busy_len: got %0d want %0d", mw_cnt, 3 * (3 * N + 1));
        end
        n_assert++;
        if (cu_cnt != 3) begin
            n_fail++;
            $display("FAIL cnt_up_pulses: got %0d want %0d", cu_cnt, 3);
        end
    endtask

    task automatic test_overflow();
        logic [17:0] g, w;
        string nm;
        sample(2, 0, 0);
        rest(2);
        sample(0, 0, 0);
        rest(1);
        sample($urandom_range(1, N), 0, 0);
        rest(1);
        sample(0, 0, 0);
        rest(1);
        while (exp_q.size() > 0) begin
            play(g, w, nm);
            n_assert++;
            if (g !== w) begin
                n_fail++;
                $display("FAIL overflow/%s: got %h want %h", nm, g, w);
            end
        end
    endtask

    task automatic test_store_drop();
        logic [17:0] g, w;
        string nm;
        int cu_cnt = 0;
        sample(0, 1, 0);
        rest(2);
        coeff(0);
        rest(1);
        while (exp_q.size() > 0) begin
            play(g, w, nm);
            cu_cnt += int'(g[2]);
            n_assert++;
            if (g !== w) begin
                n_fail++;
                $display("FAIL store_drop/%s: got %h want %h", nm, g, w);
            end
        end
        n_assert++;
        if (cu_cnt != 1) begin
            n_fail++;
            $display("FAIL drop_cnt_up: got %0d want %0d", cu_cnt, 1);
        end
    endtask

    task automatic test_priority();
        logic [17:0] g, w;
        string nm;
        add(rest_e(), 1, 1, 0, "rest_both");
        in_err = 1'b0;
        add(pk(3, 0, 0, N + 1 + cidx, 0, 1, 0), 1, 0, 0, "coeff_first");
        cidx = (cidx + 1) % N;
        sample(0, 0, 0);
        rest(1);
        while (exp_q.size() > 0) begin
            play(g, w, nm);
            n_assert++;
            if (g !== w) begin
                n_fail++;
                $display("FAIL priority/%s: got %h want %h", nm, g, w);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [17:0] g, w;
        string nm;
        sample(0, 0, 0);
        for (int i = 0; i < N + 7; i++) begin
            play(g, w, nm);
            n_assert++;
            if (g !== w) begin
                n_fail++;
                $display("FAIL reset_mid/%s: got %h want %h", nm, g, w);
            end
        end
        exp_q.delete();
        dri_q.delete();
        lci_q.delete();
        ovi_q.delete();
        nm_q.delete();
        n_assert++;
        if (op !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got op %0d want %0d", op, 6);
        end
        #2;
        n_rst = 1'b0;
        dr = 1'b0;
        lc = 1'b0;
        overflow = 1'b0;
        #1;
        n_assert++;
        if (obs !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_async: got %h want %h", obs, 18'd0);
        end
        @(negedge clk);
        n_rst  = 1'b1;
        in_err = 1'b0;
        cidx   = 0;
        coeff(0);
        rest(1);
        while (exp_q.size() > 0) begin
            play(g, w, nm);
            n_assert++;
            if (g !== w) begin
                n_fail++;
                $display("FAIL reset_after/%s: got %h want %h", nm, g, w);
            end
        end
    endtask

    task automatic test_random();
        logic [17:0] g, w;
        string nm;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       coeff(1);
                1:       sample(0, 0, 1);
                2:       sample($urandom_range(1, N), 0, 1);
                default: sample(0, 1, 1);
            endcase
            rest($urandom_range(0, 2));
        end
        rest(1);
        while (exp_q.size() > 0) begin
            play(g, w, nm);
            n_assert++;
            if (g !== w) begin
                n_fail++;
                $display("FAIL random/%s: got %h want %h", nm, g, w);
            end
        end
    endtask

    initial begin
        test_reset();
        test_coeff();
        test_sample();
        test_overflow();
        test_store_drop();
        test_priority();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_sequencer.md
Name: fir_sequencer

Overview:
- Moore controller that sequences the shared FIR datapath: register file, ALU/multiplier, and the downstream magnitude stage.
- On each new sample it shifts the sample history, stores the sample, and computes the dot product with the stored coefficients into accumulator R0.
- Loads coefficients on request, flags accumulator overflow, and holds modwait high while busy so the upstream interface stalls.

Parameters:
- NUM_TAPS, 4, number of taps N; legal range 2..7.
- Register map: samples in R1..RN, R1 oldest and RN newest; coefficients in R(N+1)..R(2N); temp in R(2N+1); accumulator R0.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- dr  in  1  new sample present on the datapath load bus.
- lc  in  1  new coefficient present on the datapath load bus.
- overflow  in  1  datapath ALU overflow for the current op, combinational.
- op  out  3  ALU op: 000 NOP, 001 COPY, 010 LOAD1 (sample bus), 011 LOAD2 (coeff bus), 100 ADD, 101 SUB, 110 MUL.
- src1  out  4  ALU source 1 register index.
- src2  out  4  ALU source 2 register index.
- dest  out  4  destination register index.
- cnt_up  out  1  one-cycle pulse per accepted sample.
- modwait  out  1  busy; high in every state except IDLE and ERR.
- err  out  1  high while in ERR.

Behaviour:
- Reset (async, n_rst=0):
  - State goes to IDLE and the coefficient index cidx goes to 0.
  - op=NOP; src1, src2 and dest = 0; cnt_up, modwait and err = 0.
- Outputs are decoded from state plus the internal counters k and cidx only.
- Inputs are sampled at the rising edge.
- IDLE:
  - lc=1 -> COEFF. lc wins if lc and dr are both 1.
  - dr=1 -> SHIFT with k=1.
  - Otherwise stay in IDLE with op=NOP.
- COEFF (1 cycle):
  - op=LOAD2, dest=N+1+cidx.
  - cidx increments modulo N, so the 5th lc with N=4 overwrites R5.
  - Next state IDLE.
- SHIFT (N-1 cycles, k=1..N-1):
  - op=COPY, src1=k+1, dest=k.
  - After k=N-1 go to STORE.
- STORE (1 cycle):
  - op=LOAD1, dest=N, cnt_up=1.
  - If dr=0 in this cycle: go to ERR. The load is still issued, and cnt_up still pulses.
  - Otherwise go to ZERO.
- ZERO (1 cycle): op=SUB, src1=0, src2=0, dest=0. Next state MUL with k=1.
- MUL: op=MUL, src1=k, src2=N+k, dest=2N+1. Next state ACC.
- ACC:
  - op=ADD, src1=0, src2=2N+1, dest=0.
  - overflow=1 -> ERR.
  - Else if k=N -> IDLE.
  - Else k+1 and back to MUL.
- Busy latency:
  - modwait rises the cycle after dr is accepted.
  - It stays high for (N-1)+1+1+2N cycles: 13 cycles for N=4.
  - It then falls in IDLE.
- ERR:
  - err=1, modwait=0, op=NOP.
  - lc=1 -> COEFF (err clears). dr=1 -> SHIFT (err clears, restart).
  - Otherwise stay in ERR.
- Busy-input rules:
  - dr and lc are ignored (not queued) in every state except IDLE, ERR and STORE; in STORE only dr is examined.
  - A level-held dr re-triggers on return to IDLE.
- Reset mid-sequence: immediate abort to the reset values. Partially shifted samples remain in the datapath; no recovery is attempted.
- Counters: k is 3 bits and cidx is 3 bits. Register indices are computed in 4-bit arithmetic; 2N+1 ≤ 15 is guaranteed by the NUM_TAPS range.

Test Plan:
1. Reset then four lc pulses, N=4 -> COEFF cycles with op=011 and dest 5,6,7,8; modwait high for one cycle each; 5th lc gives dest=5.
2. dr held for one sample, overflow=0 -> trace: COPY 1<-2, 1<-... (k=1..3: dest 1,2,3), LOAD1 dest=4 with cnt_up=1, SUB 0, then MUL/ADD pairs with src1/src2 of (1,5),(2,6),(3,7),(4,8). modwait high exactly 13 cycles; cnt_up high exactly 1 cycle.
3. overflow=1 during the 2nd ACC -> ERR next cycle with err=1, modwait=0, op=NOP; subsequent dr clears err and restarts at SHIFT k=1.
4. dr=0 in the STORE cycle -> ERR. cnt_up still pulses once.
5. dr and lc both high in IDLE -> COEFF first. Then, with dr held, SHIFT begins the cycle after COEFF returns to IDLE.
6. n_rst low in the 3rd MUL cycle -> same-cycle (async) outputs all 0, state IDLE. cidx=0 afterwards: the next lc loads dest=5.
